// File: rtl/issue_fetch_queue.sv
// issue_fetch_queue: circular instruction fetch queue feeding a multi-issue stage.
//
// Fetch fills up to FILL_W instructions per cycle (lane 0 at fill_pc, lane i at
// fill_pc+i). The oldest ISSUE_W entries are shown on the issue lanes, lane 0
// oldest, and the consumer retires issue_take of them per cycle.
//
// Ports:
//   CLOCK_50    clock, all state updates on posedge
//   rst_n       asynchronous active-low reset
//   flush       discard all entries (branch redirect)
//   fill_valid  contiguous lane-valid mask from fetch
//   fill_ir     fill instructions, lane i at [i*IW +: IW]
//   fill_pc     PC of fill lane 0
//   fetch_next  queue can accept a full fill this cycle
//   issue_valid thermometer mask of valid issue lanes
//   issue_ir    issue instructions, lane 0 oldest (0 on invalid lanes)
//   issue_pc    issue PCs (0 on invalid lanes)
//   issue_take  entries consumed this cycle from lane 0 upwards
//   count       current occupancy
//   err_ovf     sticky: fill presented while fetch_next=0
//   err_udf     sticky: issue_take exceeded the valid lanes
//
// Optional feature: define IFQ_BYPASS_EN to forward fill lanes straight to the
// issue lanes while the queue is empty (zero fill-to-issue latency).
module issue_fetch_queue #(
  parameter int unsigned IW      = 16,
  parameter int unsigned AW      = 9,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FILL_W  = 2,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                           CLOCK_50,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [FILL_W-1:0]              fill_valid,
  input  logic [FILL_W*IW-1:0]           fill_ir,
  input  logic [AW-1:0]                  fill_pc,
  output logic                           fetch_next,
  output logic [ISSUE_W-1:0]             issue_valid,
  output logic [ISSUE_W*IW-1:0]          issue_ir,
  output logic [ISSUE_W*AW-1:0]          issue_pc,
  input  logic [$clog2(ISSUE_W+1)-1:0]   issue_take,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           err_ovf,
  output logic                           err_udf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [IW-1:0] mem_ir [DEPTH];
  logic [AW-1:0] mem_pc [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          byp_act;
  logic          fill_acc;
  logic          udf_hit;
  int unsigned   fill_n;
  int unsigned   avail;
  int unsigned   take_eff;
  int unsigned   skip;
  int unsigned   store_n;
  int unsigned   rd_adv;
  logic [FILL_W-1:0] wr_en;
  logic [PW-1:0]     wr_idx [FILL_W];

  // Space check uses only the registered occupancy.
  assign fetch_next = (DEPTH - 32'(count)) >= FILL_W;

  // Bypass is only active out of reset, on an empty queue, without flush.
`ifdef IFQ_BYPASS_EN
  assign byp_act = rst_n && (count == '0) && !flush;
`else
  assign byp_act = 1'b0;
`endif

  // Issue lane view, take clamping and fill write planning.
  always_comb begin
    issue_valid = '0;
    issue_ir    = '0;
    issue_pc    = '0;
    avail       = 0;
    fill_n      = 0;
    for (int unsigned i = 0; i < FILL_W; i++) begin
      fill_n = fill_n + 32'(fill_valid[i]);
    end
    if (byp_act) begin
      for (int unsigned k = 0; k < ISSUE_W && k < FILL_W; k++) begin
        if (fill_valid[k]) begin
          issue_valid[k]         = 1'b1;
          issue_ir[k*IW +: IW]   = fill_ir[k*IW +: IW];
          issue_pc[k*AW +: AW]   = fill_pc + AW'(k);
          avail                  = avail + 1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
        if (k < 32'(count)) begin
          issue_valid[k]         = 1'b1;
          issue_ir[k*IW +: IW]   = mem_ir[rd_ptr + PW'(k)];
          issue_pc[k*AW +: AW]   = mem_pc[rd_ptr + PW'(k)];
          avail                  = avail + 1;
        end
      end
    end

    udf_hit  = 32'(issue_take) > avail;
    take_eff = udf_hit ? avail : 32'(issue_take);
    fill_acc = fetch_next && !flush;

    // Bypassed lanes consumed this cycle are never stored, and the read
    // pointer stays put because they never came from storage.
    skip    = byp_act ? take_eff : 0;
    store_n = fill_acc ? (fill_n - skip) : 0;
    rd_adv  = byp_act ? 0 : take_eff;

    for (int unsigned i = 0; i < FILL_W; i++) begin
      wr_en[i]  = fill_acc && (i >= skip) && (i < fill_n);
      wr_idx[i] = wr_ptr + PW'(i - skip);
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | ((|fill_valid) & ~fetch_next);
      err_udf <= err_udf | udf_hit;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(rd_adv);
        wr_ptr <= wr_ptr + PW'(store_n);
        count  <= CW'(32'(count) - rd_adv + store_n);
      end
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge CLOCK_50) begin
    for (int unsigned i = 0; i < FILL_W; i++) begin
      if (wr_en[i]) begin
        mem_ir[wr_idx[i]] <= fill_ir[i*IW +: IW];
        mem_pc[wr_idx[i]] <= fill_pc + AW'(i);
      end
    end
  end

endmodule

// File: tb/tb_issue_fetch_queue.sv
// Scoreboard bench for issue_fetch_queue: a queue-of-entries model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_issue_fetch_queue;

  localparam int unsigned IW      = 16;
  localparam int unsigned AW      = 9;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned FILL_W  = 2;
  localparam int unsigned ISSUE_W = 2;
  localparam int unsigned TW      = $clog2(ISSUE_W+1);
  localparam int unsigned CW      = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [FILL_W-1:0]     fill_valid = '0;
  logic [FILL_W*IW-1:0]  fill_ir = '0;
  logic [AW-1:0]         fill_pc = '0;
  logic                  fetch_next;
  logic [ISSUE_W-1:0]    issue_valid;
  logic [ISSUE_W*IW-1:0] issue_ir;
  logic [ISSUE_W*AW-1:0] issue_pc;
  logic [TW-1:0]         issue_take = '0;
  logic [CW-1:0]         count;
  logic                  err_ovf;
  logic                  err_udf;

  issue_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .FILL_W(FILL_W), .ISSUE_W(ISSUE_W)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .flush(flush), .fill_valid(fill_valid),
    .fill_ir(fill_ir), .fill_pc(fill_pc), .fetch_next(fetch_next),
    .issue_valid(issue_valid), .issue_ir(issue_ir), .issue_pc(issue_pc),
    .issue_take(issue_take), .count(count), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] ir;
    logic [AW-1:0] pc;
  } ent_t;

  typedef struct {
    int                    cnt;
    bit                    fn;
    logic [ISSUE_W-1:0]    v;
    logic [ISSUE_W*IW-1:0] ir;
    logic [ISSUE_W*AW-1:0] pc;
    bit                    ovf;
    bit                    udf;
  } exp_t;

  ent_t        model[$];
  exp_t        sb[$];
  bit          m_ovf = 0;
  bit          m_udf = 0;
  logic [AW-1:0] next_pc = '0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare the DUT against whatever the stimulus predicted.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("count",       64'(count),       64'(e.cnt));
      check("fetch_next",  64'(fetch_next),  64'(e.fn));
      check("issue_valid", 64'(issue_valid), 64'(e.v));
      check("issue_ir",    64'(issue_ir),    64'(e.ir));
      check("issue_pc",    64'(issue_pc),    64'(e.pc));
      check("err_ovf",     64'(err_ovf),     64'(e.ovf));
      check("err_udf",     64'(err_udf),     64'(e.udf));
    end
  end

  // One clock of stimulus: predict this cycle's outputs, then advance the model.
  task automatic step(input logic [FILL_W-1:0] fv, input logic [FILL_W*IW-1:0] ir,
                      input logic [TW-1:0] tk, input bit fl);
    ent_t inc[$];
    ent_t lanes[$];
    exp_t e;
    int   sz;
    int   te;
    bit   fn;
    bit   byp;
    @(posedge clk);
    #1;
    fill_valid = fv;
    fill_ir    = ir;
    fill_pc    = next_pc;
    issue_take = tk;
    flush      = fl;

    sz = model.size();
    fn = (DEPTH - sz) >= FILL_W;
    for (int i = 0; i < FILL_W; i++) begin
      if (fv[i]) inc.push_back('{ir: ir[i*IW +: IW], pc: next_pc + AW'(i)});
    end
`ifdef IFQ_BYPASS_EN
    byp = (sz == 0) && !fl;
`else
    byp = 0;
`endif
    for (int k = 0; k < ISSUE_W; k++) begin
      if (byp && k < inc.size()) lanes.push_back(inc[k]);
      if (!byp && k < sz) lanes.push_back(model[k]);
    end

    e.cnt = sz;
    e.fn  = fn;
    e.v   = '0;
    e.ir  = '0;
    e.pc  = '0;
    e.ovf = m_ovf;
    e.udf = m_udf;
    for (int k = 0; k < lanes.size(); k++) begin
      e.v[k]            = 1'b1;
      e.ir[k*IW +: IW]  = lanes[k].ir;
      e.pc[k*AW +: AW]  = lanes[k].pc;
    end
    sb.push_back(e);

    if (fv != '0 && !fn) m_ovf = 1;
    if (int'(tk) > lanes.size()) m_udf = 1;
    te = (int'(tk) > lanes.size()) ? lanes.size() : int'(tk);
    if (fl) begin
      model.delete();
    end else begin
      if (byp) begin
        foreach (inc[i]) model.push_back(inc[i]);
        repeat (te) void'(model.pop_front());
      end else begin
        repeat (te) void'(model.pop_front());
        if (fn) foreach (inc[i]) model.push_back(inc[i]);
      end
      if (fn) next_pc = next_pc + AW'(inc.size());
    end
  endtask

  // Assert reset mid-cycle with a fill pending; the queue must show empty at once.
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    fill_valid = '1;
    issue_take = TW'(1);
    flush      = 1'b0;
    model.delete();
    m_ovf = 0;
    m_udf = 0;
    e = '{cnt: 0, fn: 1, v: '0, ir: '0, pc: '0, ovf: 0, udf: 0};
    sb.push_back(e);
    @(negedge clk);
    #2;
    rst_n      = 1'b1;
    fill_valid = '0;
    issue_take = '0;
  endtask

  function automatic logic [FILL_W*IW-1:0] rnd_ir();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return (FILL_W*IW)'(r);
  endfunction

  initial begin
    do_reset();

    // First fill shows up one cycle later in order.
    next_pc = 9'h010;
    step(2'b11, {16'h6064, 16'hD102}, '0, 0);
    // Fill to full, then one more fill overflows.
    for (int i = 0; i < 4; i++) step(2'b11, rnd_ir(), '0, 0);
    // Steady take-2 / fill-2 across the wrap.
    for (int i = 0; i < 10; i++) step(2'b11, rnd_ir(), TW'(2), 0);
    // Drain to one entry, then over-take.
    while (model.size() > 1) step('0, '0, (model.size() >= 3) ? TW'(2) : TW'(1), 0);
    step('0, '0, TW'(2), 0);
    step('0, '0, '0, 0);
    // Build count=5 then flush with competing fill and take.
    step(2'b11, rnd_ir(), '0, 0);
    step(2'b11, rnd_ir(), '0, 0);
    step(2'b01, rnd_ir(), '0, 0);
    step(2'b11, rnd_ir(), TW'(2), 1);
    next_pc = 9'h040;
    step(2'b11, rnd_ir(), '0, 0);
    step('0, '0, TW'(2), 0);
    // Fill an empty queue while taking one in the same cycle.
    step(2'b11, {16'h8224, 16'h6264}, TW'(1), 0);
    step('0, '0, '0, 0);
    step('0, '0, TW'(2), 0);

    // Randomized traffic with occasional flush and one mid-run reset.
    for (int i = 0; i < 500; i++) begin
      logic [FILL_W-1:0] fv;
      int sel;
      if (i == 250) do_reset();
      sel = $urandom_range(0, 2);
      fv  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      step(fv, rnd_ir(), TW'($urandom_range(0, ISSUE_W)), ($urandom_range(0, 15) == 0));
    end
    step('0, '0, '0, 0);

    repeat (3) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
